// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTR_W       instruction / address width
//   IF_NOP_INSTR  instruction presented while nothing valid is held
//                 (condition AL, all-zero body)
//   ST_*          fetch FSM state encoding, 2 bits
//   pc_plus4      32-bit wrapping PC increment, bits [1:0] pass through
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] IF_NOP_INSTR = 32'hE000_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program-counter register with its redirect / increment mux.
// Kept separate so that a future prefetch buffer can reuse it.
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   load       take load_addr (branch redirect); wins over inc
//   load_addr  redirect target
//   inc        advance by 4 (an instruction was accepted)
//   pc         current PC
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_addr,
    input  logic               inc,
    output logic [INSTR_W-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc_plus4(pc);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Producer side of the IF/ID fetch register. Holds the PC, fetches one
// instruction at a time from the instruction cache and presents
// {PC+4, instruction} to the fetch register.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   freeze_in      hazard-unit freeze: fetch register not loading this cycle
//   branch_taken   single-cycle redirect pulse from EXE
//   branch_addr    redirect target (word aligned)
//   imem_req       fetch request to the cache
//   imem_addr      fetch address
//   imem_ready     cache returns imem_rdata this cycle
//   imem_rdata     instruction word
//   pc_out         PC+4 of the held instruction (0 when nothing held)
//   instr_out      held instruction (NOP_INSTR when nothing held)
//   instr_valid    pc_out / instr_out hold a real instruction
//   fetch_stall    ~instr_valid
//   fsm_state      fetch FSM state, for debug and checkers
//
// Handshake: a transfer happens on a rising edge where imem_req and
// imem_ready are both 1. While imem_req=1 and no transfer has happened,
// imem_addr is held stable; imem_req is never withdrawn before a transfer
// except by rst or by a redirect that coincides with the transfer.
// A redirect that arrives while a request is outstanding moves to DROP,
// which lets the stale request finish and throws its data away.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze_in,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_addr,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               fetch_stall,
    output logic [1:0]         fsm_state
);

    logic [1:0]         state;
    logic [INSTR_W-1:0] fetch_addr;
    logic [INSTR_W-1:0] pc;
    logic               pc_inc;

    // Every state redirects the PC on a branch; only an accepted
    // instruction in REQ advances it.
    assign pc_inc = (state == ST_REQ) && imem_ready && !branch_taken;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (branch_taken),
        .load_addr (branch_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fetch_addr <= RESET_PC;
            pc_out     <= '0;
            instr_out  <= NOP_INSTR;
        end else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_REQ;
                    fetch_addr <= branch_taken ? branch_addr : pc;
                end
                ST_REQ: begin
                    if (branch_taken) begin
                        if (imem_ready) begin
                            // Data for the old path arrives with the
                            // redirect: drop it and request the target.
                            fetch_addr <= branch_addr;
                            state      <= ST_REQ;
                        end else begin
                            state <= ST_DROP;
                        end
                    end else if (imem_ready) begin
                        instr_out <= imem_rdata;
                        pc_out    <= pc_plus4(pc);
                        state     <= ST_VALID;
                    end
                end
                ST_DROP: begin
                    if (imem_ready) begin
                        // pc already holds the latest target unless a
                        // newer branch lands on this very edge.
                        fetch_addr <= branch_taken ? branch_addr : pc;
                        state      <= ST_REQ;
                    end
                end
                ST_VALID: begin
                    if (branch_taken) begin
                        fetch_addr <= branch_addr;
                        pc_out     <= '0;
                        instr_out  <= NOP_INSTR;
                        state      <= ST_REQ;
                    end else if (!freeze_in) begin
                        fetch_addr <= pc;
                        pc_out     <= '0;
                        instr_out  <= NOP_INSTR;
                        state      <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state == ST_REQ) || (state == ST_DROP);
    assign imem_addr   = fetch_addr;
    assign instr_valid = (state == ST_VALID);
    assign fetch_stall = ~instr_valid;
    assign fsm_state   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk;
  logic        rst;
  logic        freeze_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_stall;
  logic [1:0]  fsm_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] salt;
  logic [63:0] exp_q[$];

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze_in    (freeze_in),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .fetch_stall  (fetch_stall),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory contents as a function of address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ salt ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs, cross one rising edge, sample 1 time unit later
  task automatic step(input logic rdy, input logic br, input logic [31:0] ba, input logic frz);
    imem_ready   = rdy;
    imem_rdata   = rdy ? mem(imem_addr) : 32'hDEAD_BEEF;
    branch_taken = br;
    branch_addr  = ba;
    freeze_in    = frz;
    @(posedge clk);
    #1;
    imem_ready   = 1'b0;
    branch_taken = 1'b0;
    freeze_in    = 1'b0;
  endtask

  // scoreboard
  task automatic push_exp(input logic [31:0] a);
    logic [31:0] p4;
    p4 = a + 32'd4;
    exp_q.push_back({p4, mem(a)});
  endtask

  task automatic pop_chk(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, pc_out);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_pc"}, pc_out, e[63:32]);
      chk({tag, "_instr"}, instr_out, e[31:0]);
    end
  endtask

  task automatic chk_empty_out(input string tag);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_stall"}, {31'd0, fetch_stall}, 32'd1);
    chk({tag, "_instr"}, instr_out, NOP);
    chk({tag, "_pc"}, pc_out, 32'd0);
  endtask

  // one full fetch at an address, ending back in REQ after consumption
  task automatic fetch_one(input string tag, input logic [31:0] a);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    push_exp(a);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    pop_chk(tag);
    chk({tag, "_noreq"}, {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    salt         = $urandom_range(32'hFFFF, 0) << 2;
    rst          = 1'b1;
    freeze_in    = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b0;
    imem_rdata   = '0;
    #22;
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk_empty_out("rst");

    // IDLE -> REQ at RESET_PC
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("idle_to_req", {30'd0, fsm_state}, {30'd0, ST_REQ});

    // back-to-back fetches with ready always high
    for (int i = 0; i < 3; i++) begin
      chk("seq_stall", {31'd0, fetch_stall}, 32'd1);
      fetch_one("seq", 32'(i * 4));
    end
    chk_empty_out("seq_after");

    // ready held low 3 cycles in REQ
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wait_addr", imem_addr, 32'd12);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_stall", {31'd0, fetch_stall}, 32'd1);
    end
    push_exp(32'd12);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    pop_chk("wait_done");

    // freeze 4 cycles in VALID
    for (int i = 0; i < 4; i++) begin
      step($urandom_range(1, 0) == 1, 1'b0, 32'd0, 1'b1);
      chk("frz_pc", pc_out, 32'd16);
      chk("frz_instr", instr_out, mem(32'd12));
      chk("frz_req", {31'd0, imem_req}, 32'd0);
      chk("frz_valid", {31'd0, instr_valid}, 32'd1);
    end
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("frz_rel_addr", imem_addr, 32'd16);
    chk("frz_rel_req", {31'd0, imem_req}, 32'd1);

    // branch in REQ without ready -> DROP, stale address held
    step(1'b0, 1'b1, 32'h100, 1'b0);
    chk("drop_state", {30'd0, fsm_state}, {30'd0, ST_DROP});
    chk("drop_addr", imem_addr, 32'd16);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("drop_hold", imem_addr, 32'd16);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("drop_done_state", {30'd0, fsm_state}, {30'd0, ST_REQ});
    chk_empty_out("drop_done");
    fetch_one("br100", 32'h100);

    // branch and ready together in REQ
    step(1'b1, 1'b1, 32'h200, 1'b0);
    chk("brrdy_state", {30'd0, fsm_state}, {30'd0, ST_REQ});
    chk_empty_out("brrdy");
    fetch_one("br200", 32'h200);

    // two branches while a stale request is outstanding: newest wins
    step(1'b0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b1, 32'h400, 1'b0);
    chk("drop2_addr", imem_addr, 32'h204);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    fetch_one("br400", 32'h400);

    // PC wrap
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    fetch_one("wrap", 32'hFFFF_FFFC);
    chk("wrap_next", imem_addr, 32'd0);

    // branch while VALID discards the held instruction
    push_exp(32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    pop_chk("pre_vbr");
    step(1'b0, 1'b1, 32'h500, 1'b1);
    chk("vbr_addr", imem_addr, 32'h500);
    chk("vbr_state", {30'd0, fsm_state}, {30'd0, ST_REQ});
    chk_empty_out("vbr");

    // reset mid-REQ
    rst = 1'b1;
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    chk_empty_out("mrst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    fetch_one("restart", 32'd0);

    // branch in IDLE
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 32'h600, 1'b0);
    chk("idlebr_state", {30'd0, fsm_state}, {30'd0, ST_REQ});
    fetch_one("idlebr", 32'h600);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
